stage2_message_sequencer: RTL and testbench
===========================================

STAGE2_MESSAGE_SEQUENCER -- requirements
Module: stage2_message_sequencer

Interface
REQ-001 Parameter SEQ_W, default 16, width of the group sequence counter.
REQ-002 Parameter ADDR_W, default 7, width of the byte read address into the stage-2 input buffer.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 in_valid  in  1  group of three decoded messages present.
REQ-006 in_ready  out  1  sequencer can accept a group.
REQ-007 m1_category, m2_category, m3_category  in  8 each  ASCII category per slot.
REQ-008 m1_type, m2_type, m3_type  in  8 each  ASCII type per slot.
REQ-009 out_valid  out  1  byte read request valid.
REQ-010 out_ready  in  1  downstream accepts the request.
REQ-011 out_addr  out  ADDR_W  byte offset of the current byte in the group buffer.
REQ-012 out_slot  out  2  slot of the current message: 1, 2 or 3; 0 when idle.
REQ-013 out_first / out_last  out  1 each  first or last byte of the current message.
REQ-014 out_ntype  out  3  N-type code of the current message.
REQ-015 grp_done  out  1  one-cycle pulse when the group completes.
REQ-016 seq_num  out  SEQ_W  count of completed sequenced groups.
REQ-017 err_unknown  out  1  one-cycle pulse when a group holds an unrecognised category.

Function
REQ-018 Block sizes by category: 'a' 35, 'd' 22, 'k' 35, 'q' 21, 'N' 12, none 0. Any other code counts as size 0 and is an unrecognised category.
REQ-019 Slot k base offset: the sum of the sizes of lower slots. Slot 1 base is 0; the maximum end is 105, below 2^ADDR_W.
REQ-020 The state machine has three states: IDLE, SEND and DONE.
REQ-021 in_ready is 1 only in IDLE.
REQ-022 A group is accepted on in_valid && in_ready. On accept, the sequencer latches all six inputs, the three sizes, the three bases and the three N-types.
REQ-023 N-type per slot: 'L' maps to 1, 'M' to 2, 'N' to 3, 'R' to 4, 'S' to 5; any other type maps to 0.
REQ-024 On accept the sequencer latches seq_flag = no slot has category 'N'.
REQ-025 After accept, the FSM moves to SEND if at least one slot has size > 0; otherwise it moves to DONE.
REQ-026 In SEND the sequencer visits slots in order 1, 2, 3 and skips slots of size 0.
REQ-027 For each visited slot, out_addr runs from base to base+size-1, one byte per out_valid && out_ready.
REQ-028 For a single slot, the sequencer issues exactly size beats.
REQ-029 Latency: if a group is accepted in cycle T, the first out_valid is asserted in cycle T+1.
REQ-030 out_valid stays 1 for every SEND cycle and has no bubbles between slots.
REQ-031 While out_valid && !out_ready, out_addr, out_slot, out_first, out_last and out_ntype hold stable.
REQ-032 out_first is 1 on the first beat of each slot. out_last is 1 on the final beat of each slot. For size 1, both would be 1, but no size-1 category exists.
REQ-033 After the last beat of the last non-empty slot is accepted, the FSM enters DONE.
REQ-034 DONE lasts exactly one cycle: grp_done is 1, then the FSM returns to IDLE. in_ready is 1 in the cycle after DONE.
REQ-035 In DONE, seq_num increments by 1 only if seq_flag is 1 and at least one slot was non-empty.
REQ-036 seq_num wraps from 2^SEQ_W-1 to 0.
REQ-037 err_unknown pulses in the cycle after accept if any slot has an unrecognised category. Processing of the valid slots continues.
REQ-038 In IDLE, out_valid, out_first, out_last and out_slot are 0, and out_addr and out_ntype are 0.

Reset
REQ-039 Reset takes priority over all other events, including in the middle of a SEND.
REQ-040 Reset state: FSM IDLE, in_ready 1, out_valid 0, out_addr 0, out_slot 0, out_first 0, out_last 0, out_ntype 0, grp_done 0, err_unknown 0, seq_num 0.
REQ-041 A group in flight at reset is discarded.

Structure
REQ-042 The shared para_def package holds: the ASCII category and type codes, including the none code; the block-size constants; the N-type codes; and the FSM state encoding.
REQ-043 There is one sub-module, stage2_slot_decode. It is instantiated three times and maps category/type to size, N-type and an unknown flag.

Verification
REQ-044 Test 1: group a/d/q, types L/M/S, out_ready=1. Required: 78 beats (addr 0-34 slot 1, 35-56 slot 2, 57-77 slot 3), out_last at addrs 34, 56 and 77, grp_done, seq_num 0->1.
REQ-045 Test 2: group none/N/k. Required: slot 2 addrs 0-11 with ntype from m2_type, slot 3 addrs 12-46, seq_num unchanged.
REQ-046 Test 3: group none/none/none. Required: no out_valid, grp_done in T+1, in_ready in T+2, seq_num unchanged.
REQ-047 Test 4: group k/k/k with out_ready toggled randomly. Required: 105 beats with strictly sequential addresses and outputs held stable during stalls.
REQ-048 Test 5: slot 1 category 'x'. Required: err_unknown pulses once, slots 2 and 3 are sequenced from base 0.
REQ-049 Test 6: rst asserted at beat 10 of Test 1, then a new group a/none/none. Required: outputs at reset values, then 35 beats from addr 0, seq_num 0->1.

Source files
------------

// File: rtl/para_def.sv
// Shared codes for the stage-2 message sequencer: ASCII categories/types,
// block sizes, N-type codes, FSM states and slot-walk helper.
package para_def;

  localparam logic [7:0] CAT_A    = 8'h61;
  localparam logic [7:0] CAT_D    = 8'h64;
  localparam logic [7:0] CAT_K    = 8'h6b;
  localparam logic [7:0] CAT_Q    = 8'h71;
  localparam logic [7:0] CAT_N    = 8'h4e;
  localparam logic [7:0] CAT_NONE = 8'h00;

  localparam logic [7:0] TYP_L = 8'h4c;
  localparam logic [7:0] TYP_M = 8'h4d;
  localparam logic [7:0] TYP_N = 8'h4e;
  localparam logic [7:0] TYP_R = 8'h52;
  localparam logic [7:0] TYP_S = 8'h53;

  localparam int unsigned SIZE_W = 6;
  localparam logic [SIZE_W-1:0] SZ_A    = 6'd35;
  localparam logic [SIZE_W-1:0] SZ_D    = 6'd22;
  localparam logic [SIZE_W-1:0] SZ_K    = 6'd35;
  localparam logic [SIZE_W-1:0] SZ_Q    = 6'd21;
  localparam logic [SIZE_W-1:0] SZ_N    = 6'd12;
  localparam logic [SIZE_W-1:0] SZ_NONE = 6'd0;

  localparam int unsigned NT_W = 3;
  localparam logic [NT_W-1:0] NT_NONE = 3'd0;
  localparam logic [NT_W-1:0] NT_L    = 3'd1;
  localparam logic [NT_W-1:0] NT_M    = 3'd2;
  localparam logic [NT_W-1:0] NT_N    = 3'd3;
  localparam logic [NT_W-1:0] NT_R    = 3'd4;
  localparam logic [NT_W-1:0] NT_S    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First non-empty slot strictly after cur (0 = none left).
  function automatic logic [1:0] next_slot(input logic [1:0] cur, input logic [2:0] nz);
    logic [1:0] r;
    r = 2'd0;
    if (cur < 2'd3 && nz[2]) r = 2'd3;
    if (cur < 2'd2 && nz[1]) r = 2'd2;
    if (cur < 2'd1 && nz[0]) r = 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/stage2_slot_decode.sv
// Combinational decode of one slot's category/type into size, N-type and unknown flag.
module stage2_slot_decode
  import para_def::*;
(
  input  logic [7:0]        category,
  input  logic [7:0]        type_code,
  output logic [SIZE_W-1:0] size_c,
  output logic [NT_W-1:0]   ntype_c,
  output logic              unknown_c
);

  always_comb begin
    size_c    = SZ_NONE;
    unknown_c = 1'b0;
    case (category)
      CAT_A:    size_c = SZ_A;
      CAT_D:    size_c = SZ_D;
      CAT_K:    size_c = SZ_K;
      CAT_Q:    size_c = SZ_Q;
      CAT_N:    size_c = SZ_N;
      CAT_NONE: size_c = SZ_NONE;
      default:  unknown_c = 1'b1;
    endcase
  end

  always_comb begin
    ntype_c = NT_NONE;
    case (type_code)
      TYP_L:   ntype_c = NT_L;
      TYP_M:   ntype_c = NT_M;
      TYP_N:   ntype_c = NT_N;
      TYP_R:   ntype_c = NT_R;
      TYP_S:   ntype_c = NT_S;
      default: ntype_c = NT_NONE;
    endcase
  end

endmodule

// File: rtl/stage2_message_sequencer.sv
// Walks the three slots of an accepted message group and issues one byte read
// request per beat, counting groups that carry no 'N' category.
module stage2_message_sequencer
  import para_def::*;
#(
  parameter int unsigned SEQ_W  = 16,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        m1_category,
  input  logic [7:0]        m2_category,
  input  logic [7:0]        m3_category,
  input  logic [7:0]        m1_type,
  input  logic [7:0]        m2_type,
  input  logic [7:0]        m3_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_slot,
  output logic              out_first,
  output logic              out_last,
  output logic [2:0]        out_ntype,
  output logic              grp_done,
  output logic [SEQ_W-1:0]  seq_num,
  output logic              err_unknown
);

  state_t            state;
  logic [7:0]        cat_q [1:3];
  logic [7:0]        typ_q [1:3];
  logic [SIZE_W-1:0] sz_q  [1:3];
  logic [ADDR_W-1:0] base_q[1:3];
  logic [NT_W-1:0]   nt_q  [1:3];
  logic              seq_flag;
  logic              nonempty;
  logic [SIZE_W-1:0] cnt;

  logic [7:0]        cat_in [1:3];
  logic [7:0]        typ_in [1:3];
  logic [7:0]        dec_cat[1:3];
  logic [7:0]        dec_typ[1:3];
  logic [SIZE_W-1:0] sz_c   [1:3];
  logic [NT_W-1:0]   nt_c   [1:3];
  logic [ADDR_W-1:0] base_c [1:3];
  logic [2:0]        unk_c;
  logic [2:0]        nz_c;
  logic [2:0]        nz_q;
  logic [1:0]        first_c;
  logic [1:0]        nxt_c;

  assign cat_in[1] = m1_category;
  assign cat_in[2] = m2_category;
  assign cat_in[3] = m3_category;
  assign typ_in[1] = m1_type;
  assign typ_in[2] = m2_type;
  assign typ_in[3] = m3_type;

  // Decoders see the live inputs while idle and the latched group otherwise.
  for (genvar i = 1; i <= 3; i++) begin : g_dec
    assign dec_cat[i] = (state == ST_IDLE) ? cat_in[i] : cat_q[i];
    assign dec_typ[i] = (state == ST_IDLE) ? typ_in[i] : typ_q[i];
    stage2_slot_decode u_dec (
      .category (dec_cat[i]),
      .type_code(dec_typ[i]),
      .size_c   (sz_c[i]),
      .ntype_c  (nt_c[i]),
      .unknown_c(unk_c[i-1])
    );
    assign nz_c[i-1] = (sz_c[i] != SZ_NONE);
    assign nz_q[i-1] = (sz_q[i] != SZ_NONE);
  end

  assign base_c[1] = '0;
  assign base_c[2] = ADDR_W'(sz_c[1]);
  assign base_c[3] = ADDR_W'(sz_c[1]) + ADDR_W'(sz_c[2]);
  assign first_c   = next_slot(2'd0, nz_c);
  assign nxt_c     = next_slot(out_slot, nz_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_slot    <= 2'd0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_ntype   <= NT_NONE;
      grp_done    <= 1'b0;
      err_unknown <= 1'b0;
      seq_num     <= '0;
      seq_flag    <= 1'b0;
      nonempty    <= 1'b0;
      cnt         <= '0;
      for (int i = 1; i <= 3; i++) begin
        cat_q[i]  <= CAT_NONE;
        typ_q[i]  <= 8'h00;
        sz_q[i]   <= SZ_NONE;
        base_q[i] <= '0;
        nt_q[i]   <= NT_NONE;
      end
    end else begin
      grp_done    <= 1'b0;
      err_unknown <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 1; i <= 3; i++) begin
              cat_q[i]  <= cat_in[i];
              typ_q[i]  <= typ_in[i];
              sz_q[i]   <= sz_c[i];
              base_q[i] <= base_c[i];
              nt_q[i]   <= nt_c[i];
            end
            in_ready    <= 1'b0;
            err_unknown <= |unk_c;
            seq_flag    <= (m1_category != CAT_N) && (m2_category != CAT_N) &&
                           (m3_category != CAT_N);
            nonempty    <= (first_c != 2'd0);
            cnt         <= '0;
            if (first_c != 2'd0) begin
              state     <= ST_SEND;
              out_valid <= 1'b1;
              out_slot  <= first_c;
              out_addr  <= base_c[first_c];
              out_first <= 1'b1;
              out_last  <= (sz_c[first_c] == SIZE_W'(1));
              out_ntype <= nt_c[first_c];
            end else begin
              state    <= ST_DONE;
              grp_done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (!out_last) begin
              cnt       <= cnt + SIZE_W'(1);
              out_addr  <= out_addr + ADDR_W'(1);
              out_first <= 1'b0;
              out_last  <= (SIZE_W'(cnt + SIZE_W'(2)) == sz_q[out_slot]);
            end else if (nxt_c != 2'd0) begin
              cnt       <= '0;
              out_slot  <= nxt_c;
              out_addr  <= base_q[nxt_c];
              out_first <= 1'b1;
              out_last  <= (sz_q[nxt_c] == SIZE_W'(1));
              out_ntype <= nt_q[nxt_c];
            end else begin
              state     <= ST_DONE;
              grp_done  <= 1'b1;
              out_valid <= 1'b0;
              out_addr  <= '0;
              out_slot  <= 2'd0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              out_ntype <= NT_NONE;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          if (seq_flag && nonempty) seq_num <= seq_num + SEQ_W'(1);
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage2_message_sequencer.sv
// Randomized bench for stage2_message_sequencer against a beat-list reference model.
module tb_stage2_message_sequencer;
  import para_def::*;

  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        m1_category, m2_category, m3_category;
  logic [7:0]        m1_type, m2_type, m3_type;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_slot;
  logic              out_first;
  logic              out_last;
  logic [2:0]        out_ntype;
  logic              grp_done;
  logic [SEQ_W-1:0]  seq_num;
  logic              err_unknown;

  int               checks = 0;
  int               errors = 0;
  logic [SEQ_W-1:0] exp_seq = '0;

  always #5 clk = ~clk;

  stage2_message_sequencer #(.SEQ_W(SEQ_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .m1_category(m1_category), .m2_category(m2_category), .m3_category(m3_category),
    .m1_type(m1_type), .m2_type(m2_type), .m3_type(m3_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_slot(out_slot), .out_first(out_first), .out_last(out_last),
    .out_ntype(out_ntype), .grp_done(grp_done), .seq_num(seq_num),
    .err_unknown(err_unknown)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cat_size(input logic [7:0] c);
    case (c)
      "a", "k": return 35;
      "d":      return 22;
      "q":      return 21;
      "N":      return 12;
      8'h00:    return 0;
      default:  return -1;
    endcase
  endfunction

  function automatic int type_code(input logic [7:0] t);
    case (t)
      "L": return 1;
      "M": return 2;
      "N": return 3;
      "R": return 4;
      "S": return 5;
      default: return 0;
    endcase
  endfunction

  // Packed view of one beat: addr, slot, first, last, ntype.
  function automatic logic [31:0] pack_beat(input int addr, input int slot, input bit f,
                                            input bit l, input int nt);
    return (32'(addr) << 16) | (32'(slot) << 8) | (32'(f) << 5) | (32'(l) << 4) | 32'(nt);
  endfunction

  function automatic logic [31:0] dut_beat();
    return pack_beat(int'(out_addr), int'(out_slot), out_first, out_last, int'(out_ntype));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_beat"}, dut_beat(), 32'd0);
    check({tag, "_ctl"}, {28'd0, in_ready, out_valid, grp_done, err_unknown}, 32'b1000);
    check({tag, "_seq"}, 32'(seq_num), 32'd0);
  endtask

  // Sends one group and follows it to completion; abort_at>0 resets after that many beats.
  task automatic run_group(input logic [7:0] c1, c2, c3, t1, t2, t3,
                           input bit rand_rdy, input int abort_at, input string name);
    logic [31:0] q[$];
    logic [7:0]  cs[3];
    logic [7:0]  ts[3];
    int          base, sz, total, popped, err_cnt, cyc;
    bit          exp_err, has_n, done;
    cs = '{c1, c2, c3};
    ts = '{t1, t2, t3};
    base = 0; exp_err = 0; has_n = 0;
    for (int s = 0; s < 3; s++) begin
      sz = cat_size(cs[s]);
      if (sz < 0) begin exp_err = 1; sz = 0; end
      if (cs[s] == "N") has_n = 1;
      for (int b = 0; b < sz; b++)
        q.push_back(pack_beat(base + b, s + 1, b == 0, b == sz - 1, type_code(ts[s])));
      base += sz;
    end
    total = q.size();

    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    m1_category = c1; m2_category = c2; m3_category = c3;
    m1_type = t1; m2_type = t2; m3_type = t3;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m1_category = 8'($urandom); m2_category = 8'($urandom); m3_category = 8'($urandom);
    m1_type = 8'($urandom); m2_type = 8'($urandom); m3_type = 8'($urandom);
    @(negedge clk);
    check({name, "_t1_valid"}, 32'(out_valid), 32'(total > 0));
    check({name, "_t1_done"}, 32'(grp_done), 32'(total == 0));

    popped = 0; err_cnt = 0; done = 0; cyc = 0;
    while (!done && cyc < 2000) begin
      if (err_unknown) err_cnt++;
      if (abort_at > 0 && popped == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs({name, "_rst"});
        rst = 1'b0;
        exp_seq = '0;
        return;
      end
      if (grp_done) begin
        check({name, "_remaining"}, 32'(q.size()), 32'd0);
        done = 1;
      end else begin
        check({name, "_busy"}, 32'(in_ready), 32'd0);
        if (!out_valid) check({name, "_valid"}, 32'(out_valid), 32'd1);
        else if (q.size() == 0) check({name, "_extra"}, dut_beat(), 32'hffff_ffff);
        else check({name, "_beat"}, dut_beat(), q[0]);
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          popped++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_timeout"}, 32'(done), 32'd1);
    if (!has_n && total > 0) exp_seq = exp_seq + SEQ_W'(1);
    @(negedge clk);
    check({name, "_pulse"}, 32'(grp_done), 32'd0);
    check({name, "_ready_after"}, 32'(in_ready), 32'd1);
    check({name, "_seq"}, 32'(seq_num), 32'(exp_seq));
    check({name, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  function automatic logic [7:0] rand_cat();
    case ($urandom_range(0, 7))
      0: return "a";
      1: return "d";
      2: return "k";
      3: return "q";
      4: return "N";
      5: return 8'h00;
      6: return 8'h00;
      default: return "x";
    endcase
  endfunction

  function automatic logic [7:0] rand_typ();
    case ($urandom_range(0, 6))
      0: return "L";
      1: return "M";
      2: return "N";
      3: return "R";
      4: return "S";
      5: return "Z";
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    m1_category = '0; m2_category = '0; m3_category = '0;
    m1_type = '0; m2_type = '0; m3_type = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_group("a", "d", "q", "L", "M", "S", 1'b0, 0, "t1_adq");
    run_group(8'h00, "N", "k", "R", "N", "L", 1'b0, 0, "t2_nk");
    run_group(8'h00, 8'h00, 8'h00, "L", "L", "L", 1'b0, 0, "t3_empty");
    run_group("k", "k", "k", "S", "R", "M", 1'b1, 0, "t4_kkk");
    run_group("x", "d", "q", "L", "M", "N", 1'b0, 0, "t5_unknown");
    run_group("a", "d", "q", "L", "M", "S", 1'b0, 10, "t6_abort");
    run_group("a", 8'h00, 8'h00, "M", "L", "L", 1'b0, 0, "t6_after");

    for (int i = 0; i < 25; i++)
      run_group(rand_cat(), rand_cat(), rand_cat(), rand_typ(), rand_typ(), rand_typ(),
                1'b1, 0, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
